// File: rtl/watch_set_ctrl_pkg.sv
// Shared types, button indices and time-field helpers for the watch set logic.
// Imported by watch_set_ctrl and its repeat generator.
package watch_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_TIME,
    ST_ALM
  } state_e;

  localparam logic [2:0] B_AP   = 3'd0;
  localparam logic [2:0] B_HINC = 3'd1;
  localparam logic [2:0] B_MINC = 3'd2;
  localparam logic [2:0] B_SINC = 3'd3;
  localparam logic [2:0] B_MODE = 3'd4;
  localparam logic [2:0] B_HDEC = 3'd5;
  localparam logic [2:0] B_MDEC = 3'd6;
  localparam logic [2:0] B_SDEC = 3'd7;

  localparam logic [6:0] HOUR_MIN = 7'd1;
  localparam logic [6:0] HOUR_MAX = 7'd12;
  localparam logic [6:0] MIN_MAX  = 7'd59;

  typedef struct packed {
    logic       ap;
    logic [6:0] hr;
    logic [6:0] mn;
  } alm_t;

  localparam alm_t ALM_RESET = '{ap: 1'b0, hr: 7'd12, mn: 7'd0};

  // Highest-priority held button: 0,1,5,2,6,3,7,4.
  function automatic logic [2:0] prio_sel(input logic [7:0] b);
    logic [2:0] s;
    s = B_AP;
    if (b[B_AP])        s = B_AP;
    else if (b[B_HINC]) s = B_HINC;
    else if (b[B_HDEC]) s = B_HDEC;
    else if (b[B_MINC]) s = B_MINC;
    else if (b[B_MDEC]) s = B_MDEC;
    else if (b[B_SINC]) s = B_SINC;
    else if (b[B_SDEC]) s = B_SDEC;
    else if (b[B_MODE]) s = B_MODE;
    return s;
  endfunction

  function automatic logic [6:0] hour_step(input logic [6:0] h,
                                           input logic up);
    if (up)
      return (h >= HOUR_MAX) ? HOUR_MIN : h + 7'd1;
    return (h <= HOUR_MIN) ? HOUR_MAX : h - 7'd1;
  endfunction

  function automatic logic [6:0] min_step(input logic [6:0] m,
                                          input logic up);
    if (up)
      return (m >= MIN_MAX) ? 7'd0 : m + 7'd1;
    return (m == 7'd0) ? MIN_MAX : m - 7'd1;
  endfunction

endpackage

// File: rtl/watch_set_ctrl_btn_repeat.sv
// Press/hold auto-repeat generator for the serviced button, timed by tick.
// Ports: held/press/restart/rep_en in, fire out (press or repeat, comb).
module watch_set_ctrl_btn_repeat
  import watch_set_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic held,
  input  logic press,
  input  logic restart,
  input  logic rep_en,
  output logic fire
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(RMAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic          rpt;

  always_comb begin
    cnt_d = cnt_q;
    rep_d = rep_q;
    rpt   = 1'b0;
    if (!held || press || restart) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (tick && rep_en) begin
      if (!rep_q && cnt_q == CW'(REPEAT_DELAY - 1)) begin
        rpt   = 1'b1;
        rep_d = 1'b1;
        cnt_d = '0;
      end else if (rep_q && cnt_q == CW'(REPEAT_RATE - 1)) begin
        rpt   = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    fire = press | rpt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch set control: button conditioning, mode FSM, alarm file and rings.
// In: clk, rst, tick_100hz, buttons, switches, time. Out: adjust pulses,
// mode, selected alarm, alm_en, ring.
module watch_set_ctrl
  import watch_set_ctrl_pkg::*;
#(
  parameter int NUM_ALARMS   = 2,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int RING_TICKS   = 6000,
  parameter int MODE_W       = $clog2(NUM_ALARMS + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_100hz,
  input  logic [7:0]            buttons,
  input  logic [7:0]            switches,
  input  logic                  ap,
  input  logic [6:0]            hour,
  input  logic [6:0]            min,
  input  logic [6:0]            sec,
  output logic                  i_a,
  output logic                  i_h,
  output logic                  i_m,
  output logic                  i_s,
  output logic                  d_h,
  output logic                  d_m,
  output logic                  d_s,
  output logic [MODE_W-1:0]     mode,
  output logic                  alm_ap,
  output logic [6:0]            alm_hour,
  output logic [6:0]            alm_min,
  output logic [NUM_ALARMS-1:0] alm_en,
  output logic [NUM_ALARMS-1:0] ring
);

  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int RW = $clog2(RING_TICKS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_ALARMS - 1);

  state_e                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [7:0]                     btn_q, btn_d;
  logic [7:0]                     bprv_q, bprv_d;
  logic [2:0]                     sel_q, sel_d;
  logic                           sw_q, sw_d;
  logic [6:0]                     sec_q, sec_d;
  logic [6:0]                     pls_q, pls_d;
  alm_t [NUM_ALARMS-1:0]          alm_q, alm_d;
  logic [NUM_ALARMS-1:0]          en_q, en_d;
  logic [NUM_ALARMS-1:0]          ring_q, ring_d;
  logic [NUM_ALARMS-1:0][RW-1:0]  rcnt_q, rcnt_d;

  logic [7:0] press;
  logic [2:0] sel;
  logic       held, chg, press_sel, rep_en;
  logic       fire, dismiss, act, alm_mode, sec_hit;
  alm_t       cur, disp;
  logic       unused_sw;

  assign unused_sw = ^switches[7:1];

  always_comb begin
    btn_d     = buttons;
    bprv_d    = btn_q;
    sw_d      = switches[0];
    sec_d     = sec;
    press     = btn_q & ~bprv_q;
    held      = |btn_q;
    sel       = prio_sel(btn_q);
    sel_d     = sel;
    chg       = sel != sel_q;
    press_sel = press[sel];
    alm_mode  = state_q == ST_ALM;
    rep_en    = !(sel == B_AP || sel == B_MODE ||
                  (alm_mode && sel == B_SINC));
    // A press while ringing only silences; it is not acted on.
    dismiss   = |ring_q && |press;
    sec_hit   = sec == 7'd0 && sec_q != 7'd0;
  end

  watch_set_ctrl_btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_rep (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick_100hz),
    .held   (held),
    .press  (press_sel),
    .restart(chg),
    .rep_en (rep_en),
    .fire   (fire)
  );

  assign act = fire & ~dismiss;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!switches[0]) begin
      state_d = ST_RUN;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!sw_q) state_d = ST_TIME;
        end
        ST_TIME: begin
          if (act && sel == B_MODE) begin
            state_d = ST_ALM;
            idx_d   = '0;
          end
        end
        ST_ALM: begin
          if (act && sel == B_MODE) begin
            if (idx_q == LAST) begin
              state_d = ST_TIME;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pls_d = '0;
    if (act && state_q == ST_TIME) begin
      unique case (sel)
        B_AP:    pls_d[6] = 1'b1;
        B_HINC:  pls_d[5] = 1'b1;
        B_MINC:  pls_d[4] = 1'b1;
        B_SINC:  pls_d[3] = 1'b1;
        B_HDEC:  pls_d[2] = 1'b1;
        B_MDEC:  pls_d[1] = 1'b1;
        B_SDEC:  pls_d[0] = 1'b1;
        default: pls_d    = '0;
      endcase
    end
  end

  always_comb begin
    alm_d = alm_q;
    en_d  = en_q;
    cur   = alm_q[idx_q];
    if (act && alm_mode) begin
      unique case (sel)
        B_AP:    cur.ap = ~cur.ap;
        B_HINC:  cur.hr = hour_step(cur.hr, 1'b1);
        B_HDEC:  cur.hr = hour_step(cur.hr, 1'b0);
        B_MINC:  cur.mn = min_step(cur.mn, 1'b1);
        B_MDEC:  cur.mn = min_step(cur.mn, 1'b0);
        B_SINC:  en_d[idx_q] = ~en_q[idx_q];
        default: cur = alm_q[idx_q];
      endcase
      alm_d[idx_q] = cur;
    end
  end

  always_comb begin
    ring_d = ring_q;
    rcnt_d = rcnt_q;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (dismiss) begin
        ring_d[k] = 1'b0;
      end else if (ring_q[k] && tick_100hz) begin
        if (rcnt_q[k] == RW'(RING_TICKS - 1))
          ring_d[k] = 1'b0;
        else
          rcnt_d[k] = rcnt_q[k] + RW'(1);
      end
      // A fresh match sets the ring and restarts its timeout.
      if (en_q[k] && sec_hit && {ap, hour, min} == alm_q[k]) begin
        ring_d[k] = 1'b1;
        rcnt_d[k] = '0;
      end
      if (!en_d[k]) ring_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      btn_q   <= '0;
      bprv_q  <= '0;
      sel_q   <= '0;
      sw_q    <= 1'b0;
      sec_q   <= '0;
      pls_q   <= '0;
      alm_q   <= {NUM_ALARMS{ALM_RESET}};
      en_q    <= '0;
      ring_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      btn_q   <= btn_d;
      bprv_q  <= bprv_d;
      sel_q   <= sel_d;
      sw_q    <= sw_d;
      sec_q   <= sec_d;
      pls_q   <= pls_d;
      alm_q   <= alm_d;
      en_q    <= en_d;
      ring_q  <= ring_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign {i_a, i_h, i_m, i_s, d_h, d_m, d_s} = pls_q;

  always_comb begin
    disp = alm_mode ? alm_q[idx_q] : alm_q[0];
    unique case (state_q)
      ST_TIME: mode = MODE_W'(1);
      ST_ALM:  mode = MODE_W'(2) + MODE_W'(idx_q);
      default: mode = '0;
    endcase
  end

  assign alm_ap   = disp.ap;
  assign alm_hour = disp.hr;
  assign alm_min  = disp.mn;
  assign alm_en   = en_q;
  assign ring     = ring_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: vector table plus
// hand sequences for repeat timing, wraps, rings and reset.
module tb_watch_set_ctrl;

  logic       clk, rst, tick_100hz;
  logic [7:0] buttons, switches;
  logic       ap;
  logic [6:0] hour, min, sec;
  logic       i_a, i_h, i_m, i_s, d_h, d_m, d_s;
  logic [1:0] mode;
  logic       alm_ap;
  logic [6:0] alm_hour, alm_min;
  logic [1:0] alm_en, ring;

  watch_set_ctrl dut (
    .clk(clk), .rst(rst), .tick_100hz(tick_100hz),
    .buttons(buttons), .switches(switches),
    .ap(ap), .hour(hour), .min(min), .sec(sec),
    .i_a(i_a), .i_h(i_h), .i_m(i_m), .i_s(i_s),
    .d_h(d_h), .d_m(d_m), .d_s(d_s),
    .mode(mode), .alm_ap(alm_ap),
    .alm_hour(alm_hour), .alm_min(alm_min),
    .alm_en(alm_en), .ring(ring)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] btn;
    logic [6:0] pls;
    int         md;
    int         ap;
    int         hr;
    int         mn;
    int         en;
  } vec_t;

  vec_t       tbl[$];
  int         ncmp = 0;
  int         nfail = 0;
  int         tphase = 0;
  logic       last_tick;
  logic [6:0] pv;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: tick strobes every 4th clk; outputs sampled #1 after.
  task automatic cyc();
    tick_100hz = (tphase == 3);
    last_tick = tick_100hz;
    tphase = (tphase + 1) % 4;
    @(posedge clk);
    #1;
    pv = {i_a, i_h, i_m, i_s, d_h, d_m, d_s};
  endtask

  task automatic tap(input logic [7:0] m, output logic [6:0] acc,
                     output int n, output int first);
    acc = '0;
    n = 0;
    first = 0;
    buttons = m;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 1) buttons = '0;
      if (pv != '0) begin
        acc |= pv;
        n++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic tap_n(input logic [7:0] m, input int cnt);
    logic [6:0] a;
    int n, f;
    for (int i = 0; i < cnt; i++) tap(m, a, n, f);
  endtask

  task automatic add(input logic [7:0] b, input logic [6:0] p,
                     input int md, input int a, input int h,
                     input int mi, input int e);
    vec_t v;
    v.btn = b; v.pls = p; v.md = md; v.ap = a;
    v.hr = h; v.mn = mi; v.en = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [6:0] acc;
    int n, first, t, np, ticks;
    int pt[8];
    logic [6:0] other;
    logic seen59, done;

    // SET_TIME taps, then alarm editing
    add(8'h01, 7'b1000000, 1, 0, 12, 0, 0);
    add(8'h02, 7'b0100000, 1, 0, 12, 0, 0);
    add(8'h04, 7'b0010000, 1, 0, 12, 0, 0);
    add(8'h08, 7'b0001000, 1, 0, 12, 0, 0);
    add(8'h20, 7'b0000100, 1, 0, 12, 0, 0);
    add(8'h40, 7'b0000010, 1, 0, 12, 0, 0);
    add(8'h80, 7'b0000001, 1, 0, 12, 0, 0);
    add(8'h06, 7'b0100000, 1, 0, 12, 0, 0);
    add(8'h24, 7'b0000100, 1, 0, 12, 0, 0);
    add(8'h90, 7'b0000001, 1, 0, 12, 0, 0);
    add(8'h10, 7'b0000000, 2, 0, 12, 0, 0);
    add(8'h20, 7'b0000000, 2, 0, 11, 0, 0);
    add(8'h02, 7'b0000000, 2, 0, 12, 0, 0);
    add(8'h02, 7'b0000000, 2, 0, 1, 0, 0);
    add(8'h20, 7'b0000000, 2, 0, 12, 0, 0);
    add(8'h40, 7'b0000000, 2, 0, 12, 59, 0);
    add(8'h04, 7'b0000000, 2, 0, 12, 0, 0);
    add(8'h01, 7'b0000000, 2, 1, 12, 0, 0);
    add(8'h08, 7'b0000000, 2, 1, 12, 0, 1);
    add(8'h10, 7'b0000000, 3, 0, 12, 0, 1);
    add(8'h02, 7'b0000000, 3, 0, 1, 0, 1);
    add(8'h08, 7'b0000000, 3, 0, 1, 0, 3);
    add(8'h08, 7'b0000000, 3, 0, 1, 0, 1);
    add(8'h10, 7'b0000000, 1, 1, 12, 0, 1);

    clk = 0; rst = 1; tick_100hz = 0;
    buttons = '0; switches = '0;
    ap = 0; hour = 7'd12; min = 7'd0; sec = 7'd0;

    // reset state
    repeat (3) cyc();
    chk("rst_pls", int'(pv), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_ap", int'(alm_ap), 0);
    chk("rst_hour", int'(alm_hour), 12);
    chk("rst_min", int'(alm_min), 0);
    chk("rst_en", int'(alm_en), 0);
    chk("rst_ring", int'(ring), 0);
    rst = 0;
    cyc();
    chk("run_mode", int'(mode), 0);

    // enter SET_TIME, single b1 tap
    switches = 8'h01;
    cyc();
    chk("set_mode", int'(mode), 1);
    tap(8'h02, acc, n, first);
    chk("b1_pls", int'(acc), 7'b0100000);
    chk("b1_cnt", n, 1);
    chk("b1_lat", first, 2);

    // hold b6: pulses at 0, +50, +60, +70 ticks
    np = 0; t = 0; other = '0;
    buttons = 8'h40;
    while (t < 76) begin
      cyc();
      if (last_tick) t++;
      other |= pv & ~7'b0000010;
      if (d_m) begin
        if (np < 8) pt[np] = t;
        np++;
      end
    end
    buttons = '0;
    repeat (120) begin
      cyc();
      other |= pv & ~7'b0000010;
      if (d_m) np++;
    end
    chk("hold_cnt", np, 4);
    chk("hold_first", int'(pt[0] <= 1), 1);
    chk("hold_gap1", pt[1] - pt[0], 50);
    chk("hold_gap2", pt[2] - pt[1], 10);
    chk("hold_gap3", pt[3] - pt[2], 10);
    chk("hold_other", int'(other), 0);

    foreach (tbl[i]) begin
      tap(tbl[i].btn, acc, n, first);
      chk($sformatf("v%0d_pls", i), int'(acc), int'(tbl[i].pls));
      chk($sformatf("v%0d_n", i), n, int'(tbl[i].pls != '0));
      chk($sformatf("v%0d_mode", i), int'(mode), tbl[i].md);
      chk($sformatf("v%0d_ap", i), int'(alm_ap), tbl[i].ap);
      chk($sformatf("v%0d_hr", i), int'(alm_hour), tbl[i].hr);
      chk($sformatf("v%0d_mn", i), int'(alm_min), tbl[i].mn);
      chk($sformatf("v%0d_en", i), int'(alm_en), tbl[i].en);
    end

    // alarm 0: 12 -> 11, twelve incs back to 11
    tap_n(8'h10, 1);
    chk("a0_mode", int'(mode), 2);
    tap_n(8'h20, 1);
    chk("a0_h11", int'(alm_hour), 11);
    tap_n(8'h02, 12);
    chk("a0_h12x", int'(alm_hour), 11);

    // hold b2 across 59 -> 00
    seen59 = 0; done = 0;
    buttons = 8'h04;
    for (int i = 0; i < 4000 && !done; i++) begin
      cyc();
      if (alm_min == 7'd59) seen59 = 1;
      if (seen59 && alm_min == 7'd0) done = 1;
    end
    buttons = '0;
    repeat (4) cyc();
    chk("b2_wrap", int'(done), 1);
    chk("b2_min", int'(alm_min), 0);
    chk("b2_hour", int'(alm_hour), 11);

    // alarm 0 to 07:30 PM (PM and enable already set)
    tap_n(8'h20, 4);
    tap_n(8'h04, 30);
    chk("a0_ap", int'(alm_ap), 1);
    chk("a0_hr", int'(alm_hour), 7);
    chk("a0_mn", int'(alm_min), 30);
    chk("a0_en", int'(alm_en), 1);
    tap_n(8'h10, 2);
    chk("back_time", int'(mode), 1);

    // match at 07:29:59 PM -> 07:30:00 PM
    ap = 1; hour = 7'd7; min = 7'd29; sec = 7'd59;
    repeat (2) cyc();
    chk("pre_ring", int'(ring), 0);
    min = 7'd30; sec = 7'd0;
    cyc();
    chk("ring_set", int'(ring), 1);

    // press dismisses and is consumed
    tap(8'h02, acc, n, first);
    chk("dis_ring", int'(ring), 0);
    chk("dis_pls", int'(acc), 0);
    chk("dis_mode", int'(mode), 1);

    // re-ring, then timeout after RING_TICKS ticks
    sec = 7'd59;
    repeat (2) cyc();
    sec = 7'd0;
    cyc();
    chk("ring2", int'(ring), 1);
    ticks = 0; done = 0;
    for (int i = 0; i < 26000 && !done; i++) begin
      cyc();
      if (last_tick) ticks++;
      if (ring == 2'b00) done = 1;
    end
    chk("to_done", int'(done), 1);
    chk("to_ticks", ticks, 6000);

    // mid-ring reset
    sec = 7'd59;
    repeat (2) cyc();
    sec = 7'd0;
    cyc();
    chk("ring3", int'(ring), 1);
    rst = 1;
    cyc();
    chk("mr_ring", int'(ring), 0);
    chk("mr_mode", int'(mode), 0);
    chk("mr_en", int'(alm_en), 0);
    chk("mr_hour", int'(alm_hour), 12);
    chk("mr_pls", int'(pv), 0);
    rst = 0;

    // switch off forces RUN; buttons produce nothing
    switches = '0;
    repeat (2) cyc();
    chk("off_mode", int'(mode), 0);
    tap(8'h02, acc, n, first);
    chk("run_pls", int'(acc), 0);
    chk("run_mode2", int'(mode), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
